// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared register map, field widths and decay default for sid_reg_if
package sid_pkg;

  localparam int FREQ_W = 16;
  localparam int PW_W   = 12;
  localparam int FC_W   = 11;
  localparam int NUM_VOICES = 3;

  localparam int unsigned DECAY_DEFAULT = 65535;

  // Voice register blocks sit back to back, seven bytes each.
  localparam logic [4:0] V1_BASE   = 5'd7;
  localparam logic [4:0] V2_BASE   = 5'd14;
  localparam logic [4:0] VOICE_END = 5'd21;

  typedef enum logic [2:0] {
    OFF_FREQ_LO = 3'd0,
    OFF_FREQ_HI = 3'd1,
    OFF_PW_LO   = 3'd2,
    OFF_PW_HI   = 3'd3,
    OFF_CTRL    = 3'd4,
    OFF_AD      = 3'd5,
    OFF_SR      = 3'd6
  } voice_off_e;

  localparam logic [4:0] ADDR_FC_LO    = 5'h15;
  localparam logic [4:0] ADDR_FC_HI    = 5'h16;
  localparam logic [4:0] ADDR_RES_FILT = 5'h17;
  localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
  localparam logic [4:0] ADDR_POTX     = 5'h19;
  localparam logic [4:0] ADDR_POTY     = 5'h1A;
  localparam logic [4:0] ADDR_OSC3     = 5'h1B;
  localparam logic [4:0] ADDR_ENV3     = 5'h1C;

endpackage

// File: rtl/sync_fall.sv
// rtl/sync_fall.sv - two-flop synchroniser with a single-cycle falling-edge strobe
module sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pre,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_vld;

  // r_armed only sets once r_s2 holds a genuinely sampled high, so a line
  // already low when reset lifts cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_vld  <= {r_vld[0], 1'b1};
      if (r_vld[1] && r_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pre  = r_s2 & ~r_s1;
  assign o_fall = r_armed & r_prev & ~r_s2;

endmodule

// File: rtl/sid_reg_if.sv
// rtl/sid_reg_if.sv - host register interface: synchronised strobe, register file, decaying bus latch
module sid_reg_if
  import sid_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = DECAY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rw,
  input  logic [4:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [FREQ_W-1:0] freq1,
  output logic [FREQ_W-1:0] freq2,
  output logic [FREQ_W-1:0] freq3,
  output logic [PW_W-1:0]   pw1,
  output logic [PW_W-1:0]   pw2,
  output logic [PW_W-1:0]   pw3,
  output logic [7:0]        ctrl1,
  output logic [7:0]        ctrl2,
  output logic [7:0]        ctrl3,
  output logic [7:0]        ad1,
  output logic [7:0]        ad2,
  output logic [7:0]        ad3,
  output logic [7:0]        sr1,
  output logic [7:0]        sr2,
  output logic [7:0]        sr3,
  output logic [FC_W-1:0]   fc,
  output logic [7:0]        res_filt,
  output logic [7:0]        mode_vol,
  input  logic [7:0]        potx,
  input  logic [7:0]        poty,
  input  logic [7:0]        osc3,
  input  logic [7:0]        env3
);

  localparam int CNT_W = $clog2(DECAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CLR = CNT_W'(DECAY_CYCLES - 1);

  logic              w_pre;
  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic              r_rw_s1;
  logic              r_rw_s2;
  logic [4:0]        r_addr;
  logic [7:0]        r_din;
  logic [7:0]        r_dout;
  logic [7:0]        r_latch;
  logic [CNT_W-1:0]  r_cnt;

  logic [FREQ_W-1:0] r_freq [NUM_VOICES];
  logic [PW_W-1:0]   r_pw   [NUM_VOICES];
  logic [7:0]        r_ctrl [NUM_VOICES];
  logic [7:0]        r_ad   [NUM_VOICES];
  logic [7:0]        r_sr   [NUM_VOICES];
  logic [FC_W-1:0]   r_fc;
  logic [7:0]        r_res_filt;
  logic [7:0]        r_mode_vol;

  logic              w_voice_hit;
  logic [1:0]        w_vidx;
  voice_off_e        w_voff;
  logic              w_ro_hit;
  logic [7:0]        w_ro_val;

  sync_fall u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cs_n),
    .o_pre  (w_pre),
    .o_fall (w_acc)
  );

  assign w_wr = w_acc & ~r_rw_s2;
  assign w_rd = w_acc &  r_rw_s2;

  always_comb begin
    w_voice_hit = 1'b1;
    w_vidx      = 2'd0;
    w_voff      = voice_off_e'(r_addr[2:0]);
    if (r_addr < V1_BASE) begin
      w_vidx = 2'd0;
    end else if (r_addr < V2_BASE) begin
      w_vidx = 2'd1;
      w_voff = voice_off_e'(3'(r_addr - V1_BASE));
    end else if (r_addr < VOICE_END) begin
      w_vidx = 2'd2;
      w_voff = voice_off_e'(3'(r_addr - V2_BASE));
    end else begin
      w_voice_hit = 1'b0;
    end
  end

  always_comb begin
    w_ro_hit = 1'b1;
    w_ro_val = 8'h00;
    case (r_addr)
      ADDR_POTX: w_ro_val = potx;
      ADDR_POTY: w_ro_val = poty;
      ADDR_OSC3: w_ro_val = osc3;
      ADDR_ENV3: w_ro_val = env3;
      default:   w_ro_hit = 1'b0;
    endcase
  end

  // addr/din are captured one cycle ahead of the strobe, while the synchroniser
  // shows the fall arriving, so the access edge acts on settled copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rw_s1    <= 1'b1;
      r_rw_s2    <= 1'b1;
      r_addr     <= '0;
      r_din      <= '0;
      r_dout     <= '0;
      r_latch    <= '0;
      r_cnt      <= '0;
      r_fc       <= '0;
      r_res_filt <= '0;
      r_mode_vol <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_freq[v] <= '0;
        r_pw[v]   <= '0;
        r_ctrl[v] <= '0;
        r_ad[v]   <= '0;
        r_sr[v]   <= '0;
      end
    end else begin
      r_rw_s1 <= rw;
      r_rw_s2 <= r_rw_s1;
      if (w_pre) begin
        r_addr <= addr;
        r_din  <= din;
      end

      if (w_wr) begin
        if (w_voice_hit) begin
          case (w_voff)
            OFF_FREQ_LO: r_freq[w_vidx][7:0]  <= r_din;
            OFF_FREQ_HI: r_freq[w_vidx][15:8] <= r_din;
            OFF_PW_LO:   r_pw[w_vidx][7:0]    <= r_din;
            OFF_PW_HI:   r_pw[w_vidx][11:8]   <= r_din[3:0];
            OFF_CTRL:    r_ctrl[w_vidx]       <= r_din;
            OFF_AD:      r_ad[w_vidx]         <= r_din;
            OFF_SR:      r_sr[w_vidx]         <= r_din;
            default: ;
          endcase
        end else begin
          case (r_addr)
            ADDR_FC_LO:    r_fc[2:0]  <= r_din[2:0];
            ADDR_FC_HI:    r_fc[10:3] <= r_din;
            ADDR_RES_FILT: r_res_filt <= r_din;
            ADDR_MODE_VOL: r_mode_vol <= r_din;
            default: ;
          endcase
        end
      end

      if (w_rd) begin
        r_dout <= w_ro_hit ? w_ro_val : r_latch;
      end

      // An access always beats decay expiry landing on the same edge.
      if (w_acc) begin
        r_cnt   <= '0;
        r_latch <= w_wr ? r_din : (w_ro_hit ? w_ro_val : r_latch);
      end else begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (r_cnt >= CNT_CLR) begin
          r_latch <= 8'h00;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign freq1    = r_freq[0];
  assign freq2    = r_freq[1];
  assign freq3    = r_freq[2];
  assign pw1      = r_pw[0];
  assign pw2      = r_pw[1];
  assign pw3      = r_pw[2];
  assign ctrl1    = r_ctrl[0];
  assign ctrl2    = r_ctrl[1];
  assign ctrl3    = r_ctrl[2];
  assign ad1      = r_ad[0];
  assign ad2      = r_ad[1];
  assign ad3      = r_ad[2];
  assign sr1      = r_sr[0];
  assign sr2      = r_sr[1];
  assign sr3      = r_sr[2];
  assign fc       = r_fc;
  assign res_filt = r_res_filt;
  assign mode_vol = r_mode_vol;

endmodule

// File: tb/tb_sid_reg_if.sv
// tb/tb_sid_reg_if.sv - self-checking bench for sid_reg_if with a snapshot scoreboard
module tb_sid_reg_if;

  localparam int D = 20;

  typedef logic [190:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        rw;
  logic [4:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [15:0] freq1, freq2, freq3;
  logic [11:0] pw1, pw2, pw3;
  logic [7:0]  ctrl1, ctrl2, ctrl3, ad1, ad2, ad3, sr1, sr2, sr3;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [7:0]  potx, poty, osc3, env3;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  vec_t  exp_q[$];
  string tag_q[$];

  logic [15:0] m_freq [3];
  logic [11:0] m_pw   [3];
  logic [7:0]  m_ctrl [3];
  logic [7:0]  m_ad   [3];
  logic [7:0]  m_sr   [3];
  logic [10:0] m_fc;
  logic [7:0]  m_res, m_mode, m_dout, m_latch;
  int          m_last_e;

  sid_reg_if #(.DECAY_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rw(rw), .addr(addr), .din(din), .dout(dout),
    .freq1(freq1), .freq2(freq2), .freq3(freq3), .pw1(pw1), .pw2(pw2), .pw3(pw3),
    .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3), .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .sr1(sr1), .sr2(sr2), .sr3(sr3), .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
    .potx(potx), .poty(poty), .osc3(osc3), .env3(env3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t dut_vec();
    return {freq1, freq2, freq3, pw1, pw2, pw3, ctrl1, ctrl2, ctrl3,
            ad1, ad2, ad3, sr1, sr2, sr3, fc, res_filt, mode_vol, dout};
  endfunction

  function automatic vec_t model_vec();
    return {m_freq[0], m_freq[1], m_freq[2], m_pw[0], m_pw[1], m_pw[2],
            m_ctrl[0], m_ctrl[1], m_ctrl[2], m_ad[0], m_ad[1], m_ad[2],
            m_sr[0], m_sr[1], m_sr[2], m_fc, m_res, m_mode, m_dout};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 3; v++) begin
      m_freq[v] = '0; m_pw[v] = '0; m_ctrl[v] = '0; m_ad[v] = '0; m_sr[v] = '0;
    end
    m_fc = '0; m_res = '0; m_mode = '0; m_dout = '0; m_latch = '0;
    m_last_e = cyc;
  endtask

  task automatic model_access(input logic rd, input logic [4:0] a, input logic [7:0] d, input int e);
    int ai;
    int v;
    logic [7:0] val;
    ai = int'(a);
    if (e - m_last_e > D) m_latch = 8'h00;
    m_last_e = e;
    if (!rd) begin
      m_latch = d;
      if (ai < 21) begin
        v = ai / 7;
        case (ai % 7)
          0: m_freq[v][7:0]  = d;
          1: m_freq[v][15:8] = d;
          2: m_pw[v][7:0]    = d;
          3: m_pw[v][11:8]   = d[3:0];
          4: m_ctrl[v]       = d;
          5: m_ad[v]         = d;
          default: m_sr[v]   = d;
        endcase
      end else begin
        case (ai)
          21: m_fc[2:0]  = d[2:0];
          22: m_fc[10:3] = d;
          23: m_res      = d;
          24: m_mode     = d;
          default: ;
        endcase
      end
    end else begin
      if (ai >= 25 && ai <= 28) begin
        case (ai)
          25: val = potx;
          26: val = poty;
          27: val = osc3;
          default: val = env3;
        endcase
        m_latch = val;
        m_dout  = val;
      end else begin
        m_dout = m_latch;
      end
    end
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      check_val({tag, "/empty_queue"}, vec_t'(1), vec_t'(0));
    end else begin
      check_val({tag_q.pop_front(), "/", tag}, dut_vec(), exp_q.pop_front());
    end
  endtask

  // Caller must be at a falling clock edge with cs_n high long enough to be seen.
  task automatic access(input logic rd, input logic [4:0] a, input logic [7:0] d,
                        input int hold, input string tag);
    exp_q.push_back(model_vec()); tag_q.push_back(tag);
    model_access(rd, a, d, cyc + 3);
    exp_q.push_back(model_vec()); tag_q.push_back(tag);
    exp_q.push_back(model_vec()); tag_q.push_back(tag);
    cs_n = 1'b0; rw = rd; addr = a; din = d;
    repeat (2) @(posedge clk);
    #1 sb_check("pre");
    @(posedge clk);
    #1 sb_check("post");
    @(negedge clk);
    repeat (hold - 3) @(negedge clk);
    cs_n = 1'b1; rw = 1'b1;
    repeat (3) @(negedge clk);
    sb_check("after");
  endtask

  task automatic decay_probe(input int idle, input logic [7:0] exp_dout, input string tag);
    access(1'b0, 5'h0E, 8'h3C, 4, {tag, "_wr"});
    while (cyc < m_last_e + idle - 3) @(negedge clk);
    access(1'b1, 5'h0E, 8'h00, 4, {tag, "_rd"});
    check_val({tag, "_dout"}, vec_t'(dout), vec_t'(exp_dout));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = '0; din = '0;
    potx = 8'h3E; poty = 8'hC1; osc3 = 8'h00; env3 = 8'h5A;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_outputs", dut_vec(), vec_t'(0));
    rst = 1'b1;
    repeat (4) @(negedge clk);

    access(1'b0, 5'h00, 8'h25, 4, "freq1_lo");
    access(1'b0, 5'h01, 8'h11, 4, "freq1_hi");
    check_val("freq1_value", vec_t'(freq1), vec_t'(16'd4389));
    check_val("freq2_freq3_zero", vec_t'({freq2, freq3}), vec_t'(0));

    access(1'b0, 5'h02, 8'hFF, 4, "pw1_lo");
    access(1'b0, 5'h03, 8'hF7, 4, "pw1_hi");
    check_val("pw1_value", vec_t'(pw1), vec_t'(12'h7FF));
    access(1'b1, 5'h03, 8'h00, 4, "rd_pw1_hi");
    check_val("rd_03_latch", vec_t'(dout), vec_t'(8'hF7));

    osc3 = 8'hA5;
    access(1'b1, 5'h1B, 8'h00, 4, "rd_osc3");
    check_val("rd_osc3_dout", vec_t'(dout), vec_t'(8'hA5));
    access(1'b1, 5'h00, 8'h00, 4, "rd_00_latch");
    check_val("rd_00_dout", vec_t'(dout), vec_t'(8'hA5));

    for (int a = 0; a < 32; a++) begin
      access(1'b0, 5'(a), 8'($urandom_range(0, 255)), 3 + (a % 3), "sweep_wr");
      access(1'b1, 5'(a), 8'h00, 3, "sweep_rd");
    end
    access(1'b1, 5'h19, 8'h00, 4, "rd_potx");
    potx = 8'h77;
    access(1'b1, 5'h1A, 8'h00, 4, "rd_poty");
    access(1'b1, 5'h1C, 8'h00, 4, "rd_env3");

    decay_probe(D + 2, 8'h00, "decay_long");
    decay_probe(D - 2, 8'h3C, "decay_short");
    decay_probe(D,     8'h3C, "decay_edge");

    access(1'b0, 5'h12, 8'h6B, 20, "hold20_ctrl3");
    check_val("hold20_ctrl3_value", vec_t'(ctrl3), vec_t'(8'h6B));

    cs_n = 1'b0; rw = 1'b0; addr = 5'h07; din = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check_val("rst_mid_access", dut_vec(), vec_t'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_val("rst_abort_freq2", vec_t'(freq2), vec_t'(0));
    check_val("rst_abort_all", dut_vec(), model_vec());
    cs_n = 1'b1; rw = 1'b1;
    repeat (4) @(negedge clk);

    access(1'b0, 5'h1D, 8'h55, 4, "wr_unused");
    access(1'b1, 5'h1D, 8'h00, 4, "rd_unused");
    check_val("rd_1d_dout", vec_t'(dout), vec_t'(8'h55));

    check_val("scoreboard_drained", vec_t'(exp_q.size()), vec_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_reg_if.md
SID_REG_IF -- requirements
Module: sid_reg_if

Interface
REQ-001 SHALL have parameter DECAY_CYCLES, default 65535, giving the clocks of bus inactivity after which the read-back bus latch clears to 0.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cs_n, input, 1 bit: host chip select, active low, asynchronous to clk.
REQ-005 SHALL have port rw, input, 1 bit: 1 = read, 0 = write, asynchronous.
REQ-006 SHALL have port addr, input, 5 bits: register address, stable from cs_n fall until cs_n rise.
REQ-007 SHALL have port din, input, 8 bits: write data, stable from cs_n fall until cs_n rise.
REQ-008 SHALL have port dout, output, 8 bits: registered read data.
REQ-009 SHALL have ports freq1, freq2, freq3, output, 16 bits each: voice frequency words feeding the phase accumulators.
REQ-010 SHALL have ports pw1, pw2, pw3, output, 12 bits each: voice pulse widths.
REQ-011 SHALL have ports ctrl1, ctrl2, ctrl3, ad1, ad2, ad3, sr1, sr2 and sr3, output, 8 bits each: voice control, attack/decay and sustain/release registers.
REQ-012 SHALL have outputs fc (11 bits), res_filt (8 bits) and mode_vol (8 bits).
REQ-013 SHALL have inputs potx, poty, osc3 and env3, 8 bits each: read-only sources.

Function
REQ-014 SHALL pass cs_n and rw through a two-flop synchroniser, then detect the falling edge of the synchronised cs_n as the single access strobe acc_stb.
REQ-015 SHALL capture addr and din in the acc_stb cycle; one access occurs per cs_n low period, and further cycles with cs_n low SHALL NOT re-trigger.
REQ-016 SHALL treat the register map as follows:
- voice v (v = 0..2) at base 7*v, offsets: +0 freq[7:0], +1 freq[15:8], +2 pw[7:0], +3 pw[11:8] (din[3:0] only), +4 ctrl, +5 ad, +6 sr;
- 0x15 fc[2:0] (din[2:0]), 0x16 fc[10:3], 0x17 res_filt, 0x18 mode_vol;
- 0x19 potx, 0x1A poty, 0x1B osc3, 0x1C env3 (read-only);
- 0x1D-0x1F unused.
REQ-017 On a write (synchronised rw = 0 at acc_stb), the addressed output SHALL change on the clock edge after acc_stb, i.e. 3 clocks after cs_n is first sampled low; no other output SHALL change.
REQ-018 Writes to 0x19-0x1F SHALL be ignored except for updating the bus latch.
REQ-019 Each byte of a multi-byte field SHALL update independently; there is no double-buffering, so freq is briefly half-updated between lo and hi writes.
REQ-020 On a read of 0x19-0x1C, dout SHALL load the live input value on the edge after acc_stb and hold it until the next access.
REQ-021 On a read of any other address, dout SHALL load the bus latch.
REQ-022 The bus latch SHALL load din on every write and the returned value on every read of 0x19-0x1C.
REQ-023 A decay counter SHALL reset to 0 on every acc_stb and increment saturating otherwise; when it reaches DECAY_CYCLES, the latch SHALL clear to 0x00.
REQ-024 dout SHALL NOT decay; it SHALL show the decayed value only on a subsequent read.
REQ-025 If acc_stb coincides with decay expiry, the access SHALL win: the latch loads the new value and the counter restarts.
REQ-026 An access whose cs_n low period is shorter than 2 clocks may be missed; the host SHALL hold cs_n low for at least 3 clocks.

Reset
REQ-027 While rst = 0, all outputs SHALL be 0 and the synchroniser flops SHALL be 1 (idle); the bus latch, decay counter and captured addr/din SHALL also be 0.
REQ-028 A reset asserted mid-access SHALL abort it.
REQ-029 After rst rises, a cs_n already low SHALL NOT produce acc_stb until it has been seen high.

Structure
REQ-030 Register address constants, the field widths (16/12/11) and the DECAY_CYCLES default SHALL live in shared package sid_pkg.
REQ-031 The synchroniser and edge detector SHALL be a sub-module sync_fall (2-flop sync plus falling-edge pulse), instantiated for cs_n; rw uses the sync path only.

Verification
REQ-032 Write 0x00 <= 0x25, then 0x01 <= 0x11 -> freq1 = 16'd4389 three clocks after the second cs_n fall; freq2 and freq3 stay 0.
REQ-033 Write 0x02 <= 0xFF, then 0x03 <= 0xF7 -> pw1 = 12'h7FF (upper nibble dropped); a read of 0x03 returns 0xF7 from the latch.
REQ-034 osc3 = 0xA5, read 0x1B -> dout = 0xA5; then read 0x00 with no intervening write -> dout = 0xA5 (latch).
REQ-035 Write 0x0E <= 0x3C, idle DECAY_CYCLES+2 clocks, read 0x0E -> dout = 0x00; repeat with DECAY_CYCLES-2 idle clocks -> dout = 0x3C.
REQ-036 Hold cs_n low 20 clocks for one write -> exactly one register update; assert rst during the 2nd synchroniser cycle of a write -> target register stays 0.
REQ-037 Write 0x1D <= 0x55 -> no output changes; a read of 0x1D returns 0x55.
